// File: rtl/hazard_unit.sv
// -----------------------------------------------------------------------------
// hazard_unit
//   Hazard detection and forwarding unit for the 5-stage pipelined core.
//   Tracks source/destination register indices through E/M/W, detects
//   load-use hazards against the decode stage, generates stall/flush controls
//   and the ALU operand forward selects. Two saturating event counters
//   (load-use stall cycles, redirect flushes) support performance checking.
//
// Ports
//   Clk           core clock, rising edge
//   Reset         asynchronous active-low reset
//   Rs1_D/Rs2_D   decode-stage source register indices
//   Rd_D          decode-stage destination register index
//   Result_Src_0  E-stage instruction is a load
//   RegWrite_M/W  M/W-stage instruction writes the register file
//   PCSrc_E       taken branch/jump resolved in E
//   Count_Clear   synchronous clear of both counters (beats increment)
//   Stall_F/D     hold PC / IF-ID register
//   Flush_D/E     clear IF-ID / ID-IEX register
//   Forward_A_E   operand A select: 00 regfile, 10 M result, 01 W result
//   Forward_B_E   operand B select, same encoding
//   Stall_Count   saturating count of load-use stall cycles
//   Flush_Count   saturating count of redirect flush events
// -----------------------------------------------------------------------------
module hazard_unit #(
  parameter int REG_W = 5,
  parameter int CNT_W = 16
) (
  input  logic             Clk,
  input  logic             Reset,
  input  logic [REG_W-1:0] Rs1_D,
  input  logic [REG_W-1:0] Rs2_D,
  input  logic [REG_W-1:0] Rd_D,
  input  logic             Result_Src_0,
  input  logic             RegWrite_M,
  input  logic             RegWrite_W,
  input  logic             PCSrc_E,
  input  logic             Count_Clear,
  output logic             Stall_F,
  output logic             Stall_D,
  output logic             Flush_D,
  output logic             Flush_E,
  output logic [1:0]       Forward_A_E,
  output logic [1:0]       Forward_B_E,
  output logic [CNT_W-1:0] Stall_Count,
  output logic [CNT_W-1:0] Flush_Count
);

  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  logic [REG_W-1:0] rs1_e, rs2_e, rd_e, rd_m, rd_w;
  logic             lw_stall;

  // A load in E whose destination is read by the instruction in D cannot be
  // forwarded in time; x0 is excluded because it is never really written.
  assign lw_stall = Result_Src_0 & (rd_e != '0) &
                    ((rd_e == Rs1_D) | (rd_e == Rs2_D));

  // A redirect discards D anyway, so it overrides the stall.
  assign Stall_F = lw_stall & ~PCSrc_E;
  assign Stall_D = lw_stall & ~PCSrc_E;
  assign Flush_D = PCSrc_E;
  assign Flush_E = lw_stall | PCSrc_E;

  // M is checked before W so the newest producer wins.
  always_comb begin
    // NOTE: defaults first so every path assigns the selects and no latch is inferred.
    Forward_A_E = 2'b00;
    Forward_B_E = 2'b00;
    if (RegWrite_M && (rd_m == rs1_e) && (rs1_e != '0))
      Forward_A_E = 2'b10;
    else if (RegWrite_W && (rd_w == rs1_e) && (rs1_e != '0))
      Forward_A_E = 2'b01;
    if (RegWrite_M && (rd_m == rs2_e) && (rs2_e != '0))
      Forward_B_E = 2'b10;
    else if (RegWrite_W && (rd_w == rs2_e) && (rs2_e != '0))
      Forward_B_E = 2'b01;
  end

  // Index pipeline: E takes a bubble on flush; M and W always advance.
  always_ff @(posedge Clk or negedge Reset) begin
    if (!Reset) begin
      rs1_e <= '0;
      rs2_e <= '0;
      rd_e  <= '0;
      rd_m  <= '0;
      rd_w  <= '0;
    end else begin
      // NOTE: non-blocking so each stage captures its predecessor's pre-edge value.
      if (Flush_E) begin
        rs1_e <= '0;
        rs2_e <= '0;
        rd_e  <= '0;
      end else begin
        rs1_e <= Rs1_D;
        rs2_e <= Rs2_D;
        rd_e  <= Rd_D;
      end
      rd_m <= rd_e;
      rd_w <= rd_m;
    end
  end

  // Saturating event counters; clear takes priority over increment.
  always_ff @(posedge Clk or negedge Reset) begin
    if (!Reset) begin
      Stall_Count <= '0;
      Flush_Count <= '0;
    end else if (Count_Clear) begin
      Stall_Count <= '0;
      Flush_Count <= '0;
    end else begin
      if (Stall_D && (Stall_Count != CNT_MAX))
        Stall_Count <= Stall_Count + CNT_W'(1);
      if (PCSrc_E && (Flush_Count != CNT_MAX))
        Flush_Count <= Flush_Count + CNT_W'(1);
    end
  end

endmodule

// File: tb/tb_hazard_unit.sv
// -----------------------------------------------------------------------------
// tb_hazard_unit
//   Self-checking bench for hazard_unit. Two instances share the stimulus:
//   one with 16-bit counters and one with 2-bit counters for saturation.
//   A behavioural model keeps the in-flight instructions of E/M/W as records
//   and derives stalls, flushes, forwards and counters from them.
// -----------------------------------------------------------------------------
module tb_hazard_unit;

  localparam int REG_W = 5;

  logic             Clk = 1'b0;
  logic             Reset = 1'b0;
  logic [REG_W-1:0] Rs1_D = '0, Rs2_D = '0, Rd_D = '0;
  logic             Result_Src_0 = 1'b0, RegWrite_M = 1'b0, RegWrite_W = 1'b0;
  logic             PCSrc_E = 1'b0, Count_Clear = 1'b0;

  logic        Stall_F, Stall_D, Flush_D, Flush_E;
  logic [1:0]  Forward_A_E, Forward_B_E;
  logic [15:0] Stall_Count, Flush_Count;

  logic        s_stall_f, s_stall_d, s_flush_d, s_flush_e;
  logic [1:0]  s_fwd_a, s_fwd_b;
  logic [1:0]  s_stall_count, s_flush_count;

  hazard_unit #(.REG_W(REG_W), .CNT_W(16)) dut (
    .Clk(Clk), .Reset(Reset), .Rs1_D(Rs1_D), .Rs2_D(Rs2_D), .Rd_D(Rd_D),
    .Result_Src_0(Result_Src_0), .RegWrite_M(RegWrite_M), .RegWrite_W(RegWrite_W),
    .PCSrc_E(PCSrc_E), .Count_Clear(Count_Clear),
    .Stall_F(Stall_F), .Stall_D(Stall_D), .Flush_D(Flush_D), .Flush_E(Flush_E),
    .Forward_A_E(Forward_A_E), .Forward_B_E(Forward_B_E),
    .Stall_Count(Stall_Count), .Flush_Count(Flush_Count)
  );

  hazard_unit #(.REG_W(REG_W), .CNT_W(2)) dut_sat (
    .Clk(Clk), .Reset(Reset), .Rs1_D(Rs1_D), .Rs2_D(Rs2_D), .Rd_D(Rd_D),
    .Result_Src_0(Result_Src_0), .RegWrite_M(RegWrite_M), .RegWrite_W(RegWrite_W),
    .PCSrc_E(PCSrc_E), .Count_Clear(Count_Clear),
    .Stall_F(s_stall_f), .Stall_D(s_stall_d), .Flush_D(s_flush_d), .Flush_E(s_flush_e),
    .Forward_A_E(s_fwd_a), .Forward_B_E(s_fwd_b),
    .Stall_Count(s_stall_count), .Flush_Count(s_flush_count)
  );

  always #5 Clk = ~Clk;

  // One in-flight instruction; pipe[0]=E, pipe[1]=M, pipe[2]=W.
  typedef struct packed {
    logic [REG_W-1:0] rs1;
    logic [REG_W-1:0] rs2;
    logic [REG_W-1:0] rd;
  } instr_t;

  instr_t pipe [3];
  int     stall_cnt, flush_cnt, stall_cnt2, flush_cnt2;
  int     total = 0;
  int     bad = 0;

  task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Newest writer among M and W that targets src; x0 never forwards.
  function automatic logic [1:0] fwd(input logic [REG_W-1:0] src);
    if (src == '0) return 2'b00;
    if (RegWrite_M && pipe[1].rd == src) return 2'b10;
    if (RegWrite_W && pipe[2].rd == src) return 2'b01;
    return 2'b00;
  endfunction

  function automatic int next_count(input int c, input bit ev, input bit clr, input int max);
    if (clr) return 0;
    if (ev && c < max) return c + 1;
    return c;
  endfunction

  task automatic model_reset();
    for (int i = 0; i < 3; i++) pipe[i] = '0;
    stall_cnt = 0; flush_cnt = 0; stall_cnt2 = 0; flush_cnt2 = 0;
  endtask

  task automatic check_all(input bit exp_stall, input bit exp_flush_e);
    check("stall_f", 16'(Stall_F), 16'(exp_stall));
    check("stall_d", 16'(Stall_D), 16'(exp_stall));
    check("flush_d", 16'(Flush_D), 16'(PCSrc_E));
    check("flush_e", 16'(Flush_E), 16'(exp_flush_e));
    check("fwd_a", 16'(Forward_A_E), 16'(fwd(pipe[0].rs1)));
    check("fwd_b", 16'(Forward_B_E), 16'(fwd(pipe[0].rs2)));
    check("stall_count", Stall_Count, 16'(stall_cnt));
    check("flush_count", Flush_Count, 16'(flush_cnt));
    check("sat_stall_count", 16'(s_stall_count), 16'(stall_cnt2));
    check("sat_flush_count", 16'(s_flush_count), 16'(flush_cnt2));
  endtask

  // One clock: drive at the falling edge, check mid-cycle, advance model at
  // the rising edge (only while out of reset).
  task automatic step(input logic [REG_W-1:0] rs1, input logic [REG_W-1:0] rs2,
                      input logic [REG_W-1:0] rd, input bit ld, input bit rwm,
                      input bit rww, input bit pc, input bit clr);
    bit hazard, stall;
    @(negedge Clk);
    Rs1_D = rs1; Rs2_D = rs2; Rd_D = rd;
    Result_Src_0 = ld; RegWrite_M = rwm; RegWrite_W = rww;
    PCSrc_E = pc; Count_Clear = clr;
    #1;
    hazard = ld && pipe[0].rd != '0 && (pipe[0].rd == rs1 || pipe[0].rd == rs2);
    stall  = hazard && !pc;
    check_all(stall, hazard || pc);
    @(posedge Clk);
    if (Reset) begin
      pipe[2] = pipe[1];
      pipe[1] = pipe[0];
      pipe[0] = (hazard || pc) ? instr_t'('0) : instr_t'({rs1, rs2, rd});
      stall_cnt  = next_count(stall_cnt,  stall, clr, 65535);
      flush_cnt  = next_count(flush_cnt,  pc,    clr, 65535);
      stall_cnt2 = next_count(stall_cnt2, stall, clr, 3);
      flush_cnt2 = next_count(flush_cnt2, pc,    clr, 3);
    end
  endtask

  initial begin
    model_reset();

    // Reset held with Rd_D=5 and a redirect pulse: nothing advances.
    step(0, 0, 5, 0, 1, 1, 0, 0);
    step(5, 5, 5, 1, 1, 1, 1, 0);
    #2 Reset = 1'b1;

    // First edge after release loads Rd_E=5; a load reading r5 must stall.
    step(0, 0, 5, 0, 0, 0, 0, 0);
    step(5, 0, 0, 1, 0, 0, 0, 0);
    step(0, 0, 0, 0, 0, 0, 0, 0);

    // RAW from M on operand A, then on operand B.
    step(0, 0, 3, 0, 0, 0, 0, 0);
    step(3, 0, 0, 0, 0, 0, 0, 0);
    step(0, 0, 0, 0, 1, 0, 0, 0);
    step(0, 0, 3, 0, 0, 0, 0, 0);
    step(0, 3, 0, 0, 0, 0, 0, 0);
    step(0, 0, 0, 0, 1, 0, 0, 0);

    // Double hit on r4 (M wins), then W-only forward, then x0 never forwards.
    step(0, 0, 4, 0, 0, 0, 0, 0);
    step(0, 0, 4, 0, 0, 0, 0, 0);
    step(4, 4, 0, 0, 0, 0, 0, 0);
    step(0, 0, 0, 0, 1, 1, 0, 0);
    step(0, 0, 4, 0, 0, 0, 0, 0);
    step(0, 0, 0, 0, 0, 0, 0, 0);
    step(4, 0, 0, 0, 0, 0, 0, 0);
    step(0, 0, 0, 0, 0, 1, 0, 0);
    step(0, 0, 0, 0, 1, 1, 0, 0);
    step(0, 0, 0, 0, 1, 1, 0, 0);

    // Load-use on Rs2, then a redirect, then both together.
    step(0, 0, 7, 0, 0, 0, 0, 0);
    step(0, 7, 0, 1, 0, 0, 0, 0);
    step(1, 2, 3, 0, 0, 0, 1, 0);
    step(1, 2, 3, 0, 0, 0, 0, 0);
    step(0, 0, 7, 0, 0, 0, 0, 0);
    step(7, 0, 0, 1, 0, 0, 1, 0);
    step(0, 0, 0, 0, 0, 0, 0, 0);

    // Five load-use stalls: the 2-bit counter sticks at 3.
    for (int i = 0; i < 5; i++) begin
      step(0, 0, 6, 0, 0, 0, 0, 0);
      step(6, 0, 0, 1, 0, 0, 0, 0);
    end
    // Clear with a concurrent stall: 0 next cycle, then 1 after another stall.
    step(0, 0, 6, 0, 0, 0, 0, 0);
    step(6, 0, 0, 1, 0, 0, 0, 1);
    step(0, 0, 6, 0, 0, 0, 0, 0);
    step(6, 0, 0, 1, 0, 0, 0, 0);
    step(0, 0, 0, 0, 0, 0, 0, 0);
    check("sat_after_clear", 16'(s_stall_count), 16'd1);

    // Reset asserted mid-stall: Rd_E clears at once, so the stall drops.
    step(0, 0, 7, 0, 0, 0, 0, 0);
    @(negedge Clk);
    Rs1_D = 7; Rs2_D = 0; Rd_D = 0;
    Result_Src_0 = 1'b1; RegWrite_M = 1'b0; RegWrite_W = 1'b0;
    PCSrc_E = 1'b0; Count_Clear = 1'b0;
    #1 check("pre_reset_stall", 16'(Stall_D), 16'd1);
    Reset = 1'b0;
    #1 model_reset();
    check_all(1'b0, 1'b0);
    step(7, 7, 7, 1, 1, 1, 0, 0);
    #2 Reset = 1'b1;

    // Randomized traffic over a small register set to provoke hazards.
    for (int i = 0; i < 400; i++) begin
      step(REG_W'($urandom_range(0, 7)), REG_W'($urandom_range(0, 7)),
           REG_W'($urandom_range(0, 7)), bit'($urandom_range(0, 1)),
           bit'($urandom_range(0, 1)), bit'($urandom_range(0, 1)),
           ($urandom_range(0, 4) == 0), ($urandom_range(0, 19) == 0));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
